// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
// Multi-cycle fetch/control stage in front of the I/R-type execute datapath.
// Holds the program counter and a small writable instruction memory. Each
// instruction passes through FETCH, DECODE, EXEC and WB, so the downstream
// datapath never sees two instructions overlap.
//
// Ports
//   clk         : single clock, rising-edge
//   rst         : asynchronous active-high reset
//   start       : leave HALT and restart at RESET_PC (ignored elsewhere)
//   stall       : hold in FETCH while high (sampled in FETCH only)
//   imem_we     : instruction memory write enable
//   imem_waddr  : word index to write
//   imem_wdata  : word to write
//   instr       : current instruction for the execute stage
//   ALUOp       : ALU operation class for the execute stage
//   reg_write   : register-file write enable, high only during WB
//   pc          : current program counter
//   instr_valid : instr/ALUOp/reg_write belong to a live instruction
//   halted      : block is in HALT
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   instr,
  output logic [1:0]                    ALUOp,
  output logic                          reg_write,
  output logic [63:0]                   pc,
  output logic                          instr_valid,
  output logic                          halted
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]    state_r;
  logic          wr_dec_r;
  logic [31:0]   imem_r [IMEM_DEPTH];
  logic [AW-1:0] rd_idx_s;
  logic          in_range_s;

  // Opcode to {ALUOp, write}. Unknown opcodes become NOPs rather than halting.
  function automatic logic [2:0] decode_op(input logic [6:0] opc);
    logic [2:0] res;
    case (opc)
      7'b0110011: res = {2'b10, 1'b1};  // R-type
      7'b0010011: res = {2'b10, 1'b1};  // I-type ALU
      7'b0000011: res = {2'b00, 1'b1};  // load
      7'b0100011: res = {2'b00, 1'b0};  // store
      7'b1100011: res = {2'b01, 1'b0};  // branch
      default:    res = {2'b00, 1'b0};  // NOP
    endcase
    return res;
  endfunction

  // Full word index is compared, so PCs past the memory halt instead of aliasing.
  assign in_range_s = (pc[63:2] < 62'(IMEM_DEPTH));
  assign rd_idx_s   = pc[AW+1:2];

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_r[imem_waddr] <= imem_wdata;
    end
  end

  // Sequencer and registered execute-stage outputs. The FETCH read samples the
  // memory before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      ALUOp       <= 2'b00;
      reg_write   <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      wr_dec_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_FETCH;
        end
        S_FETCH: begin
          if (!in_range_s) begin
            state_r <= S_HALT;
            halted  <= 1'b1;
          end else if (stall) begin
            state_r <= S_FETCH;
          end else begin
            instr       <= imem_r[rd_idx_s];
            instr_valid <= 1'b1;
            state_r     <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (instr == 32'h0) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            state_r     <= S_HALT;
          end else begin
            {ALUOp, wr_dec_r} <= decode_op(instr[6:0]);
            state_r           <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Write enable rises entering WB so it is high for WB only.
          reg_write <= wr_dec_r;
          state_r   <= S_WB;
        end
        S_WB: begin
          reg_write   <= 1'b0;
          instr_valid <= 1'b0;
          pc          <= pc + 64'd4;
          state_r     <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            pc      <= RESET_PC;
            halted  <= 1'b0;
            state_r <= S_FETCH;
          end else begin
            state_r <= S_HALT;
          end
        end
        default: begin
          // Unreachable encodings recover through IDLE with outputs quiet.
          reg_write   <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
